lab_cu_gen: RTL and testbench

//  Parametrised successor to the lab control unit: multi-cycle Moore/Mealy FSM sequencing datapath
//  (IR, PC, A reg, ALU, memory) through START->FETCH->DECODE->EXEC->FETCH. Adds 4-bit opcode mode
//  (16 instrs, 3-bit ALUop), programmable memory-read latency, OUT register strobe, optional halt resume.

---
 rtl/lab_cu_gen_if.sv | 19 +
 rtl/lab_cu_gen.sv | 127 ++++++++++++
 tb/tb_lab_cu_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lab_cu_gen_if.sv
// Control-unit <-> datapath bundle: flags and opcode in, datapath strobes and debug state out.
interface lab_cu_gen_if #(parameter int OPW = 3);
  logic           enter, Aeq0, Apos;
  logic [OPW-1:0] IR;
  logic           IRload, PCload, JMPmux, Meminst, MemWr;
  logic [1:0]     Asel;
  logic           Aload, OutLoad;
  logic [2:0]     ALUop;
  logic           Halt;
  logic [4:0]     StateNo;

  // master = control unit, slave = datapath/operator side
  modport master (input  enter, Aeq0, Apos, IR,
                  output IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, OutLoad,
                         ALUop, Halt, StateNo);
  modport slave  (output enter, Aeq0, Apos, IR,
                  input  IRload, PCload, JMPmux, Meminst, MemWr, Asel, Aload, OutLoad,
                         ALUop, Halt, StateNo);
endinterface

// File: rtl/lab_cu_gen.sv
// Multi-cycle control unit: START->FETCH->DECODE->EXEC_op->FETCH with programmable
// memory-read latency, optional 16-op table and optional resume from HALT.
module lab_cu_gen #(
  parameter int OPW         = 3,
  parameter int MEM_LAT     = 0,
  parameter int HALT_RESUME = 0
) (
  input  logic          clock,
  input  logic          reset,
  lab_cu_gen_if.master  bus
);
  localparam logic [4:0] S_START  = 5'h00;
  localparam logic [4:0] S_FETCH  = 5'h01;
  localparam logic [4:0] S_DECODE = 5'h02;
  localparam logic [4:0] S_EXEC   = 5'h10;

  localparam logic [3:0] OP_IN  = 4'h0, OP_STORE = 4'h1, OP_LOAD = 4'h2, OP_ADD = 4'h3,
                         OP_SUB = 4'h4, OP_JZ    = 4'h5, OP_JPOS = 4'h6, OP_HALT = 4'h7,
                         OP_AND = 4'h8, OP_OR    = 4'h9, OP_NOT  = 4'hA, OP_INC  = 4'hB,
                         OP_DEC = 4'hC, OP_OUT   = 4'hD, OP_JMP  = 4'hE;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  logic [4:0] r_state, w_next;
  logic [3:0] r_wcnt;
  logic [3:0] w_op, w_xop;
  logic       w_exec, w_memrd, w_done;
  logic       w_irload, w_pcload, w_jmpmux, w_meminst, w_memwr, w_aload, w_outload, w_halt;
  logic [1:0] w_asel;
  logic [2:0] w_aluop;

  assign w_op   = 4'(bus.IR);
  assign w_xop  = r_state[3:0];
  // with a 3-bit opcode, codes 5'h18..5'h1F are not legal states
  assign w_exec = r_state[4] && ((OPW > 3) || !r_state[3]);
  assign w_done = (r_wcnt == LAT);
  assign w_memrd = (r_state == S_FETCH) ||
                   (w_exec && (w_xop == OP_LOAD || w_xop == OP_ADD || w_xop == OP_SUB ||
                               w_xop == OP_AND  || w_xop == OP_OR));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_START;
      r_wcnt  <= 4'd0;
    end else begin
      r_state <= w_next;
      // leaving a read state always happens at LAT, so the counter never wraps
      r_wcnt  <= (w_memrd && w_next == r_state) ? r_wcnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    w_next    = S_START;
    w_irload  = 1'b0;
    w_pcload  = 1'b0;
    w_jmpmux  = 1'b0;
    w_meminst = 1'b0;
    w_memwr   = 1'b0;
    w_asel    = 2'b00;
    w_aload   = 1'b0;
    w_outload = 1'b0;
    w_aluop   = 3'b111;
    w_halt    = 1'b0;
    case (r_state)
      S_START:  w_next = S_FETCH;
      S_FETCH: begin
        w_next   = w_done ? S_DECODE : S_FETCH;
        w_irload = w_done;
        w_pcload = w_done;
      end
      S_DECODE: begin
        w_meminst = 1'b1;
        w_next    = S_EXEC | {1'b0, w_op};
      end
      default: if (w_exec) begin
        w_next = S_FETCH;
        case (w_xop)
          OP_IN: begin
            w_asel  = 2'b10;
            w_aload = bus.enter;
            if (!bus.enter) w_next = r_state;
          end
          OP_STORE: begin
            w_meminst = 1'b1;
            w_memwr   = 1'b1;
          end
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_meminst = 1'b1;
            w_aload   = w_done;
            if (!w_done) w_next = r_state;
            case (w_xop)
              OP_LOAD: w_asel  = 2'b01;
              OP_ADD:  w_aluop = 3'b000;
              OP_SUB:  w_aluop = 3'b001;
              OP_AND:  w_aluop = 3'b010;
              default: w_aluop = 3'b011;
            endcase
          end
          OP_JZ:   begin w_jmpmux = 1'b1; w_pcload = bus.Aeq0; end
          OP_JPOS: begin w_jmpmux = 1'b1; w_pcload = bus.Apos; end
          OP_HALT: begin
            w_halt = 1'b1;
            w_next = (HALT_RESUME != 0 && bus.enter) ? S_FETCH : r_state;
          end
          OP_NOT:  begin w_aluop = 3'b100; w_aload = 1'b1; end
          OP_INC:  begin w_aluop = 3'b101; w_aload = 1'b1; end
          OP_DEC:  begin w_aluop = 3'b110; w_aload = 1'b1; end
          OP_OUT:  w_outload = 1'b1;
          OP_JMP:  begin w_jmpmux = 1'b1; w_pcload = 1'b1; end
          default: ;
        endcase
      end
    endcase
  end

  assign bus.IRload  = w_irload;
  assign bus.PCload  = w_pcload;
  assign bus.JMPmux  = w_jmpmux;
  assign bus.Meminst = w_meminst;
  assign bus.MemWr   = w_memwr;
  assign bus.Asel    = w_asel;
  assign bus.Aload   = w_aload;
  assign bus.OutLoad = w_outload;
  assign bus.ALUop   = w_aluop;
  assign bus.Halt    = w_halt;
  assign bus.StateNo = r_state;
endmodule

// File: tb/tb_lab_cu_gen.sv
// Four parameter variants share one stimulus; a phase-level model is checked every cycle.
module tb_lab_cu_gen;
  localparam int N = 4;

  typedef struct packed {
    logic       irload, pcload, jmpmux, meminst, memwr;
    logic [1:0] asel;
    logic       aload, outload;
    logic [2:0] aluop;
    logic       halt;
    logic [4:0] stno;
  } out_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enter = 1'b0, aeq0 = 1'b0, apos = 1'b0;
  logic [3:0] ir = 4'd0;
  logic       chk_on = 1'b0;
  int         n_cmp = 0, n_bad = 0;

  always #5 clock = ~clock;

  lab_cu_gen_if #(.OPW(3)) if0 ();
  lab_cu_gen_if #(.OPW(4)) if1 ();
  lab_cu_gen_if #(.OPW(4)) if2 ();
  lab_cu_gen_if #(.OPW(4)) if3 ();

  assign if0.enter = enter; assign if0.Aeq0 = aeq0; assign if0.Apos = apos; assign if0.IR = ir[2:0];
  assign if1.enter = enter; assign if1.Aeq0 = aeq0; assign if1.Apos = apos; assign if1.IR = ir;
  assign if2.enter = enter; assign if2.Aeq0 = aeq0; assign if2.Apos = apos; assign if2.IR = ir;
  assign if3.enter = enter; assign if3.Aeq0 = aeq0; assign if3.Apos = apos; assign if3.IR = ir;

  lab_cu_gen #(.OPW(3), .MEM_LAT(0),  .HALT_RESUME(0)) u0 (.clock(clock), .reset(reset), .bus(if0));
  lab_cu_gen #(.OPW(4), .MEM_LAT(3),  .HALT_RESUME(1)) u1 (.clock(clock), .reset(reset), .bus(if1));
  lab_cu_gen #(.OPW(4), .MEM_LAT(5),  .HALT_RESUME(0)) u2 (.clock(clock), .reset(reset), .bus(if2));
  lab_cu_gen #(.OPW(4), .MEM_LAT(15), .HALT_RESUME(1)) u3 (.clock(clock), .reset(reset), .bus(if3));

  out_t act [N];
  assign act[0] = {if0.IRload, if0.PCload, if0.JMPmux, if0.Meminst, if0.MemWr, if0.Asel,
                   if0.Aload, if0.OutLoad, if0.ALUop, if0.Halt, if0.StateNo};
  assign act[1] = {if1.IRload, if1.PCload, if1.JMPmux, if1.Meminst, if1.MemWr, if1.Asel,
                   if1.Aload, if1.OutLoad, if1.ALUop, if1.Halt, if1.StateNo};
  assign act[2] = {if2.IRload, if2.PCload, if2.JMPmux, if2.Meminst, if2.MemWr, if2.Asel,
                   if2.Aload, if2.OutLoad, if2.ALUop, if2.Halt, if2.StateNo};
  assign act[3] = {if3.IRload, if3.PCload, if3.JMPmux, if3.Meminst, if3.MemWr, if3.Asel,
                   if3.Aload, if3.OutLoad, if3.ALUop, if3.Halt, if3.StateNo};

  function automatic int p_opw(int k); return (k == 0) ? 3 : 4; endfunction
  function automatic int p_lat(int k);
    case (k) 0: return 0; 1: return 3; 2: return 5; default: return 15; endcase
  endfunction
  function automatic bit p_hr(int k); return (k == 1 || k == 3); endfunction

  // model: phase 0 start, 1 fetch, 2 decode, 3 execute; age = cycles spent in phase
  int m_ph [N], m_op [N], m_age [N];

  function automatic bit is_rd(int op);
    return op == 2 || op == 3 || op == 4 || op == 8 || op == 9;
  endfunction
  function automatic logic [2:0] alu_of(int op);
    case (op)
      3: return 3'd0; 4: return 3'd1; 8: return 3'd2; 9: return 3'd3;
      10: return 3'd4; 11: return 3'd5; 12: return 3'd6; default: return 3'd7;
    endcase
  endfunction

  function automatic out_t model_out(int k);
    out_t e;
    bit   done;
    int   op;
    e = '0;
    e.aluop = 3'b111;
    done = (m_age[k] == p_lat(k));
    op = m_op[k];
    case (m_ph[k])
      1: begin e.stno = 5'd1; e.irload = done; e.pcload = done; end
      2: begin e.stno = 5'd2; e.meminst = 1'b1; end
      3: begin
        e.stno = 5'(16 + op);
        if (is_rd(op)) begin
          e.meminst = 1'b1; e.aload = done; e.aluop = alu_of(op);
          e.asel = (op == 2) ? 2'b01 : 2'b00;
        end else case (op)
          0:  begin e.asel = 2'b10; e.aload = enter; end
          1:  begin e.meminst = 1'b1; e.memwr = 1'b1; end
          5:  begin e.jmpmux = 1'b1; e.pcload = aeq0; end
          6:  begin e.jmpmux = 1'b1; e.pcload = apos; end
          7:  e.halt = 1'b1;
          10, 11, 12: begin e.aluop = alu_of(op); e.aload = 1'b1; end
          13: e.outload = 1'b1;
          14: begin e.jmpmux = 1'b1; e.pcload = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
    return e;
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < N; k++) begin
      if (reset) begin
        m_ph[k] <= 0; m_age[k] <= 0; m_op[k] <= 0;
      end else begin
        case (m_ph[k])
          0: begin m_ph[k] <= 1; m_age[k] <= 0; end
          1: if (m_age[k] == p_lat(k)) begin m_ph[k] <= 2; m_age[k] <= 0; end
             else m_age[k] <= m_age[k] + 1;
          2: begin
            m_ph[k] <= 3; m_age[k] <= 0;
            m_op[k] <= (p_opw(k) == 3) ? int'(ir[2:0]) : int'(ir);
          end
          default: begin
            if (is_rd(m_op[k])) begin
              if (m_age[k] == p_lat(k)) begin m_ph[k] <= 1; m_age[k] <= 0; end
              else m_age[k] <= m_age[k] + 1;
            end else if (m_op[k] == 0) begin
              if (enter) m_ph[k] <= 1;
            end else if (m_op[k] == 7) begin
              if (p_hr(k) && enter) m_ph[k] <= 1;
            end else m_ph[k] <= 1;
          end
        endcase
      end
    end
  end

  always @(negedge clock) begin
    if (chk_on) begin
      for (int k = 0; k < N; k++) begin
        out_t e;
        e = model_out(k);
        n_cmp++;
        if (act[k] !== e) begin
          n_bad++;
          $display("FAIL model u%0d t=%0t: got %h expected %h", k, $time, act[k], e);
        end
      end
    end
  end

  task automatic chk(string nm, logic [7:0] a, logic [7:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s t=%0t: got %h expected %h", nm, $time, a, e);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  logic [2:0] alu_hc [8];
  out_t       rst_pat;

  initial begin
    alu_hc = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b111, 3'b111};
    rst_pat = '0;
    rst_pat.aluop = 3'b111;
    #1 reset = 1'b1;
    #1 chk_on = 1'b1;
    tick(2);
    chk("rst_u0", 8'(act[0]), 8'(rst_pat));
    chk("rst_u3_hi", 8'(act[3] >> 8), 8'(rst_pat >> 8));
    reset = 1'b0;

    // IN waits for enter
    ir = 4'h0; enter = 1'b0;
    tick(1);  chk("in_fetch", 8'(if0.StateNo), 8'h01);
    tick(1);  chk("in_decode", 8'(if0.StateNo), 8'h02);
    tick(20); chk("in_hold", 8'(if0.StateNo), 8'h10);
    chk("in_noload", 8'(if0.Aload), 8'h0);
    enter = 1'b1; #1;
    chk("in_aload", 8'(if0.Aload), 8'h1);
    chk("in_asel", 8'(if0.Asel), 8'h2);
    tick(1);  chk("in_ret", 8'(if0.StateNo), 8'h01);
    enter = 1'b0;

    // LOAD with MEM_LAT=3
    do_reset(); ir = 4'h2;
    tick(1);  chk("lat3_fetch0_ir", 8'(if1.IRload), 8'h0);
    tick(3);  chk("lat3_fetch3_ir", 8'(if1.IRload), 8'h1);
    chk("lat3_fetch3_pc", 8'(if1.PCload), 8'h1);
    tick(1);  chk("lat3_decode", 8'(if1.StateNo), 8'h02);
    tick(1);  chk("lat3_load0", 8'(if1.Aload), 8'h0);
    chk("lat3_load_st", 8'(if1.StateNo), 8'h12);
    tick(2);  chk("lat3_load2", 8'(if1.Aload), 8'h0);
    tick(1);  chk("lat3_load3", 8'(if1.Aload), 8'h1);
    chk("lat3_asel", 8'(if1.Asel), 8'h1);
    tick(1);  chk("lat3_ret", 8'(if1.StateNo), 8'h01);

    // conditional jumps are Mealy on the flags
    do_reset(); ir = 4'h5; aeq0 = 1'b0;
    tick(3);  chk("jz_jmux", 8'(if0.JMPmux), 8'h1);
    chk("jz_nt", 8'(if0.PCload), 8'h0);
    aeq0 = 1'b1; #1; chk("jz_t", 8'(if0.PCload), 8'h1);
    aeq0 = 1'b0;
    do_reset(); ir = 4'h6; apos = 1'b0;
    tick(3);  chk("jpos_nt", 8'(if0.PCload), 8'h0);
    apos = 1'b1; #1; chk("jpos_t", 8'(if0.PCload), 8'h1);
    apos = 1'b0;

    // upper half of the 16-op table
    for (int i = 8; i < 16; i++) begin
      do_reset(); ir = 4'(i);
      tick(6);
      chk($sformatf("op%0h_st", i), 8'(if1.StateNo), 8'(8'h10 + i));
      chk($sformatf("op%0h_alu", i), 8'(if1.ALUop), 8'(alu_hc[i-8]));
      chk($sformatf("op%0h_out", i), 8'(if1.OutLoad), (i == 13) ? 8'h1 : 8'h0);
      chk($sformatf("op%0h_pc", i), 8'(if1.PCload), (i == 14) ? 8'h1 : 8'h0);
    end

    // HALT: terminal vs resumable
    do_reset(); ir = 4'h7; enter = 1'b0;
    tick(70);
    chk("halt_u0", 8'(if0.Halt), 8'h1);
    chk("halt_u0_st", 8'(if0.StateNo), 8'h17);
    chk("halt_u1", 8'(if1.Halt), 8'h1);
    enter = 1'b1;
    tick(1);
    chk("halt_u1_res", 8'(if1.StateNo), 8'h01);
    chk("halt_u0_stay", 8'(if0.StateNo), 8'h17);
    chk("halt_u2_stay", 8'(if2.StateNo), 8'h17);
    enter = 1'b0;

    // async reset in the middle of a MEM_LAT=5 LOAD
    do_reset(); ir = 4'h2;
    tick(10);
    chk("mid_st", 8'(if2.StateNo), 8'h12);
    chk("mid_mi", 8'(if2.Meminst), 8'h1);
    reset = 1'b1; #1;
    chk("mid_rst_st", 8'(if2.StateNo), 8'h00);
    chk("mid_rst_all", 8'(act[2]), 8'(rst_pat));
    chk("mid_rst_hi", 8'(act[2] >> 8), 8'(rst_pat >> 8));
    tick(2);
    reset = 1'b0;
    tick(20);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
